// File: rtl/patch_unembedding.sv
// Patch unembedding: projects each token back to PH*PW*C pixels via a bias plus
// an E-term MAC, and streams the image out in raster order over valid/ready.
module patch_unembedding #(
  parameter int DATA_WIDTH = 4,
  parameter int IMG_H      = 32,
  parameter int IMG_W      = 32,
  parameter int C          = 3,
  parameter int PH         = 16,
  parameter int PW         = 16,
  parameter int E          = 8,
  localparam int PATCH_SIZE  = PH * PW * C,
  localparam int NUM_PATCHES = (IMG_H / PH) * (IMG_W / PW),
  localparam int NUM_PIX     = IMG_H * IMG_W * C
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DATA_WIDTH*NUM_PATCHES*E-1:0]   patch_in,
  input  logic [DATA_WIDTH*E*PATCH_SIZE-1:0]    W_unembed_in,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]      b_unembed_in,
  output logic [DATA_WIDTH-1:0]                 pix_data,
  output logic                                  pix_valid,
  input  logic                                  pix_ready,
  output logic                                  pix_last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int GY_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CC_W = (C > 1) ? $clog2(C) : 1;
  localparam int EI_W = (E > 1) ? $clog2(E) : 1;
  localparam int P_W  = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1;
  localparam int K_W  = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_MAC   = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] tok_q [NUM_PATCHES][E];
  logic [DATA_WIDTH-1:0] w_q   [E][PATCH_SIZE];
  logic [DATA_WIDTH-1:0] b_q   [PATCH_SIZE];

  logic [GY_W-1:0]       gy_q, gy_d;
  logic [GX_W-1:0]       gx_q, gx_d;
  logic [CC_W-1:0]       cc_q, cc_d;
  logic [EI_W-1:0]       e_idx_q, e_idx_d;
  logic [31:0]           acc_q, acc_d;
  logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  pix_last_q, pix_last_d;

  logic [P_W-1:0]          p_s;
  logic [K_W-1:0]          k_s;
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [31:0]             acc_next_s;
  logic                    is_last_s;
  logic                    mac_end_s;
  logic                    handshake_s;

  // Raster position -> (patch, in-patch offset); matches the embedding stage layout.
  assign p_s = P_W'((int'(gy_q) / PH) * (IMG_W / PW) + int'(gx_q) / PW);
  assign k_s = K_W'(((int'(gy_q) % PH) * PW + int'(gx_q) % PW) * C + int'(cc_q));

  assign prod_s      = {{DATA_WIDTH{1'b0}}, tok_q[p_s][e_idx_q]} *
                       {{DATA_WIDTH{1'b0}}, w_q[e_idx_q][k_s]};
  assign acc_next_s  = acc_q + {{(32-2*DATA_WIDTH){1'b0}}, prod_s};
  assign is_last_s   = (gy_q == GY_W'(IMG_H-1)) && (gx_q == GX_W'(IMG_W-1)) &&
                       (cc_q == CC_W'(C-1));
  assign mac_end_s   = (e_idx_q == EI_W'(E-1));
  assign handshake_s = pix_valid_q && pix_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD; else state_d = S_IDLE;
      S_LOAD:  state_d = S_SETUP;
      S_SETUP: state_d = S_MAC;
      S_MAC:   if (mac_end_s) state_d = S_EMIT; else state_d = S_MAC;
      S_EMIT: begin
        if (handshake_s) state_d = pix_last_q ? S_DONE : S_SETUP;
        else             state_d = S_EMIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: counters, accumulator and output pixel registers
  always_comb begin
    gy_d        = gy_q;
    gx_d        = gx_q;
    cc_d        = cc_q;
    e_idx_d     = e_idx_q;
    acc_d       = acc_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    case (state_q)
      S_LOAD: begin
        gy_d    = '0;
        gx_d    = '0;
        cc_d    = '0;
        e_idx_d = '0;
        acc_d   = 32'd0;
      end
      S_SETUP: begin
        acc_d   = {{(32-DATA_WIDTH){1'b0}}, b_q[k_s]};
        e_idx_d = '0;
      end
      S_MAC: begin
        acc_d = acc_next_s;
        if (mac_end_s) begin
          e_idx_d     = '0;
          pix_data_d  = acc_next_s[DATA_WIDTH-1:0];
          pix_valid_d = 1'b1;
          pix_last_d  = is_last_s;
        end else begin
          e_idx_d = e_idx_q + EI_W'(1);
        end
      end
      S_EMIT: begin
        if (handshake_s) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          if (pix_last_q) begin
            cc_d = cc_q;
          end else if (cc_q != CC_W'(C-1)) begin
            cc_d = cc_q + CC_W'(1);
          end else if (gx_q != GX_W'(IMG_W-1)) begin
            cc_d = '0;
            gx_d = gx_q + GX_W'(1);
          end else begin
            cc_d = '0;
            gx_d = '0;
            gy_d = gy_q + GY_W'(1);
          end
        end else begin
          pix_valid_d = pix_valid_q;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gy_q        <= '0;
      gx_q        <= '0;
      cc_q        <= '0;
      e_idx_q     <= '0;
      acc_q       <= 32'd0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      gy_q        <= gy_d;
      gx_q        <= gx_d;
      cc_q        <= cc_d;
      e_idx_q     <= e_idx_d;
      acc_q       <= acc_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
    end
  end

  // Operand snapshot; always written in S_LOAD before any read, so no reset needed
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int p = 0; p < NUM_PATCHES; p++)
        for (int e = 0; e < E; e++)
          tok_q[p][e] <= patch_in[((p*E)+e)*DATA_WIDTH +: DATA_WIDTH];
      for (int e = 0; e < E; e++)
        for (int k = 0; k < PATCH_SIZE; k++)
          w_q[e][k] <= W_unembed_in[((e*PATCH_SIZE)+k)*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 0; k < PATCH_SIZE; k++)
        b_q[k] <= b_unembed_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign pix_last  = pix_last_q;

endmodule

// File: tb/tb_patch_unembedding.sv
// Directed, table-driven bench for patch_unembedding on a 4x4x1 image, 2x2 patches, E=2.
module tb_patch_unembedding;

  localparam int DW   = 4;
  localparam int E    = 2;
  localparam int NP   = 4;
  localparam int PS   = 4;
  localparam int NPIX = 16;
  localparam int NVEC = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             pix_ready = 1'b1;
  logic [DW*NP*E-1:0] patch_in = '0;
  logic [DW*E*PS-1:0] w_in = '0;
  logic [DW*PS-1:0]   b_in = '0;
  logic [DW-1:0]    pix_data;
  logic             pix_valid, pix_last, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] patch;
    logic [31:0] w;
    logic [15:0] b;
    logic [63:0] exp;
    int          stall_beat;
    int          stall_len;
    int          abort_beat;
    bit          poke;
  } vec_t;

  vec_t vecs [NVEC];

  patch_unembedding #(
    .DATA_WIDTH(DW), .IMG_H(4), .IMG_W(4), .C(1), .PH(2), .PW(2), .E(E)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .patch_in(patch_in), .W_unembed_in(w_in), .b_unembed_in(b_in),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [63:0] e, input int n);
    return e[n*4 +: 4];
  endfunction

  task automatic run_frame(input vec_t v);
    int cyc, beat, stalled, first_cyc, done_cyc;
    bit got_done, in_stall;
    @(negedge clk);
    patch_in = v.patch; w_in = v.w; b_in = v.b; pix_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; beat = 0; stalled = 0; first_cyc = -1; done_cyc = -1;
    got_done = 1'b0; in_stall = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int t = 0; t < 400 && !got_done; t++) begin
      if (v.poke && cyc == 2) begin
        patch_in = '1; w_in = '1; b_in = '1;
      end
      start = v.poke && (cyc == 3);
      if (in_stall) chk("valid_held", 64'(pix_valid), 64'd1);
      if (pix_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (v.abort_beat == beat) begin
          rst = 1'b1;
          #1;
          chk("abort_data",  64'(pix_data),  64'd0);
          chk("abort_valid", 64'(pix_valid), 64'd0);
          chk("abort_last",  64'(pix_last),  64'd0);
          chk("abort_busy",  64'(busy),      64'd0);
          chk("abort_done",  64'(done),      64'd0);
          @(negedge clk);
          rst = 1'b0;
          pix_ready = 1'b1;
          repeat (6) begin
            @(negedge clk);
            chk("post_abort_done", 64'(done), 64'd0);
            chk("post_abort_busy", 64'(busy), 64'd0);
          end
          return;
        end
        chk("beat_data", 64'(pix_data), 64'(nib(v.exp, beat)));
        chk("beat_last", 64'(pix_last), 64'(beat == NPIX-1));
        if (beat == v.stall_beat && stalled < v.stall_len) begin
          pix_ready = 1'b0; stalled++; in_stall = 1'b1;
        end else begin
          pix_ready = 1'b1; beat++; in_stall = 1'b0;
        end
      end else begin
        pix_ready = cyc[0];
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("beats_at_done", 64'(beat), 64'(NPIX));
        if (v.poke) start = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("frame_done_seen", 64'(got_done), 64'd1);
    chk("first_valid_cycle", 64'(first_cyc), 64'(E + 3));
    chk("done_cycle", 64'(done_cyc), 64'((E + 2) * NPIX + 2 + v.stall_len));
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
    pix_ready = 1'b1;
  endtask

  initial begin
    // all ones: 1*1+1*1 = 2
    vecs[0] = '{patch: 32'h1111_1111, w: 32'h1111_1111, b: 16'h0000,
                exp: 64'h2222_2222_2222_2222, stall_beat: -1, stall_len: 0, abort_beat: -1, poke: 1'b0};
    // bias only, b[k]=k
    vecs[1] = '{patch: 32'h1234_5678, w: 32'h0000_0000, b: 16'h3210,
                exp: 64'h3232_1010_3232_1010, stall_beat: -1, stall_len: 0, abort_beat: -1, poke: 1'b0};
    // truncation: 15*15*2+15 = 465 -> 1
    vecs[2] = '{patch: 32'hFFFF_FFFF, w: 32'hFFFF_FFFF, b: 16'hFFFF,
                exp: 64'h1111_1111_1111_1111, stall_beat: -1, stall_len: 0, abort_beat: -1, poke: 1'b0};
    // token[p]={p+1,1}, W[0][k]=1, W[1][k]=k -> pixel = p+1+k
    vecs[3] = '{patch: 32'h1413_1211, w: 32'h3210_1111, b: 16'h0000,
                exp: 64'h7665_5443_5443_3221, stall_beat: -1, stall_len: 0, abort_beat: -1, poke: 1'b0};
    vecs[4] = '{patch: 32'h1111_1111, w: 32'h1111_1111, b: 16'h0000,
                exp: 64'h2222_2222_2222_2222, stall_beat: 3, stall_len: 7, abort_beat: -1, poke: 1'b0};
    vecs[5] = '{patch: 32'h1413_1211, w: 32'h3210_1111, b: 16'h0000,
                exp: 64'h7665_5443_5443_3221, stall_beat: -1, stall_len: 0, abort_beat: 6, poke: 1'b0};
    vecs[6] = '{patch: 32'h1413_1211, w: 32'h3210_1111, b: 16'h0000,
                exp: 64'h7665_5443_5443_3221, stall_beat: -1, stall_len: 0, abort_beat: -1, poke: 1'b0};
    vecs[7] = '{patch: 32'h1413_1211, w: 32'h3210_1111, b: 16'h0000,
                exp: 64'h7665_5443_5443_3221, stall_beat: 9, stall_len: 2, abort_beat: -1, poke: 1'b1};

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_data",  64'(pix_data),  64'd0);
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_last",  64'(pix_last),  64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_frame(vecs[i]);
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
